// File: rtl/pipeline_sort_n_if.sv
// rtl/pipeline_sort_n_if.sv - client/sort handshake bundle for the streaming sorter
interface pipeline_sort_n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8
);
  logic                            client_val;
  logic                            client_rdy;
  logic [NUM_ELEMS*DATA_WIDTH-1:0] client_data;
  logic                            client_desc;
  logic                            sort_val;
  logic                            sort_rdy;
  logic [NUM_ELEMS*DATA_WIDTH-1:0] sort_data;

  modport master (
    output client_val, client_data, client_desc, sort_rdy,
    input  client_rdy, sort_val, sort_data
  );

  modport slave (
    input  client_val, client_data, client_desc, sort_rdy,
    output client_rdy, sort_val, sort_data
  );
endinterface

// File: rtl/pipeline_sort_n.sv
// rtl/pipeline_sort_n.sv - pipelined odd-even transposition sorter, one beat per cycle
module pipeline_sort_n #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8,
  parameter int SIGNED     = 0
) (
  input logic              clk,
  input logic              rst,
  pipeline_sort_n_if.slave bus
);
  localparam int NW = NUM_ELEMS * DATA_WIDTH;

  logic [NW-1:0]          st_data [NUM_ELEMS];
  logic [NUM_ELEMS-1:0]   st_val;
  // The last stage never compares, so it carries no direction bit.
  logic [NUM_ELEMS-2:0]   st_desc;
  logic [NW-1:0]          nxt     [NUM_ELEMS];
  logic                   adv;

  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  function automatic logic [NW-1:0] cx(input logic [NW-1:0] d, input logic desc, input logic odd);
    logic [NW-1:0]         r;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  swap;
    r = d;
    for (int j = 0; j < NUM_ELEMS - 1; j++) begin
      if ((j % 2 == 1) == odd) begin
        a    = r[j*DATA_WIDTH +: DATA_WIDTH];
        b    = r[(j+1)*DATA_WIDTH +: DATA_WIDTH];
        swap = desc ? gt(b, a) : gt(a, b);
        if (swap) begin
          r[j*DATA_WIDTH +: DATA_WIDTH]     = b;
          r[(j+1)*DATA_WIDTH +: DATA_WIDTH] = a;
        end
      end
    end
    return r;
  endfunction

  assign adv            = ~st_val[NUM_ELEMS-1] | bus.sort_rdy;
  assign bus.client_rdy = adv & ~rst;
  assign bus.sort_val   = st_val[NUM_ELEMS-1];
  assign bus.sort_data  = st_data[NUM_ELEMS-1];

  always_comb begin
    nxt[0] = cx(bus.client_data, bus.client_desc, 1'b0);
    for (int k = 1; k < NUM_ELEMS; k++) begin
      nxt[k] = cx(st_data[k-1], st_desc[k-1], (k % 2) == 1);
    end
  end

  // Whole pipeline moves in lockstep; bubbles stay where they are.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_val  <= '0;
      st_desc <= '0;
      for (int k = 0; k < NUM_ELEMS; k++) st_data[k] <= '0;
    end else if (adv) begin
      st_val[0]  <= bus.client_val & bus.client_rdy;
      st_desc[0] <= bus.client_desc;
      st_data[0] <= nxt[0];
      for (int k = 1; k < NUM_ELEMS; k++) begin
        st_val[k]  <= st_val[k-1];
        st_data[k] <= nxt[k];
      end
      for (int k = 1; k < NUM_ELEMS - 1; k++) st_desc[k] <= st_desc[k-1];
    end
  end
endmodule

// File: tb/tb_pipeline_sort_n.sv
// tb/tb_pipeline_sort_n.sv - scoreboard bench for pipeline_sort_n, unsigned and signed instances
module tb_pipeline_sort_n;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_sort_n_if #(.DATA_WIDTH(W), .NUM_ELEMS(N)) bu ();
  pipeline_sort_n_if #(.DATA_WIDTH(W), .NUM_ELEMS(N)) bs ();

  assign bs.client_val  = bu.client_val;
  assign bs.client_data = bu.client_data;
  assign bs.client_desc = bu.client_desc;
  assign bs.sort_rdy    = bu.sort_rdy;

  pipeline_sort_n #(.DATA_WIDTH(W), .NUM_ELEMS(N), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(bu));
  pipeline_sort_n #(.DATA_WIDTH(W), .NUM_ELEMS(N), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(bs));

  logic [31:0] q_u[$];
  logic [31:0] q_s[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bu.sort_val) begin
      if (q_u.size() == 0) check("unexpected_u", 1, 0);
      else begin
        check("data_u", bu.sort_data, q_u[0]);
        if (bu.sort_rdy) void'(q_u.pop_front());
      end
      if (!bu.sort_rdy) check("stall_rdy_u", bu.client_rdy, 0);
    end
    if (!rst && bs.sort_val) begin
      if (q_s.size() == 0) check("unexpected_s", 1, 0);
      else begin
        check("data_s", bs.sort_data, q_s[0]);
        if (bs.sort_rdy) void'(q_s.pop_front());
      end
    end
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic desc, input bit sgn);
    logic [7:0] e [4];
    logic [7:0] t;
    logic [31:0] r;
    int j;
    for (int i = 0; i < 4; i++) e[i] = d[i*8 +: 8];
    for (int i = 1; i < 4; i++) begin
      t = e[i];
      j = i - 1;
      while (j >= 0 && ((sgn ? e[j] ^ 8'h80 : e[j]) > (sgn ? t ^ 8'h80 : t))) begin
        e[j+1] = e[j];
        j--;
      end
      e[j+1] = t;
    end
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = desc ? e[3-i] : e[i];
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic desc, input logic [31:0] eu,
                      input logic [31:0] es, output bit ok);
    ok = 0;
    bu.client_val  = 1'b1;
    bu.client_data = d;
    bu.client_desc = desc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bu.client_rdy) begin
        q_u.push_back(eu);
        q_s.push_back(es);
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bu.client_val = 1'b0;
  endtask

  task automatic latency(input string name);
    int lat;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bu.sort_val) begin lat = i; break; end
    end
    check(name, lat, 4);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q_u.size() != 0 || q_s.size() != 0); i++) @(posedge clk);
    check("drain_u", q_u.size(), 0);
    check("drain_s", q_s.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_in  [6] = '{32'h00203010, 32'h06010505, 32'h1140007F,
                              32'h44113322, 32'h01010101, 32'h00020103};
  logic [31:0] bp_exp [6] = '{32'h30201000, 32'h01050506, 32'h7F401100,
                              32'h11223344, 32'h01010101, 32'h00010203};
  logic        bp_desc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bit ok;
    logic [31:0] d;
    logic dsc;
    bu.client_val  = 1'b0;
    bu.client_data = '0;
    bu.client_desc = 1'b0;
    bu.sort_rdy    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_client_rdy", bu.client_rdy, 0);
    check("rst_sort_val", bu.sort_val, 0);
    check("rst_sort_data", bu.sort_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bu.sort_rdy = 1'b0;
    @(negedge clk);
    check("empty_rdy", bu.client_rdy, 1);
    @(posedge clk); #1;
    bu.sort_rdy = 1'b1;

    send(32'h02070209, 1'b0, 32'h09070202, 32'h09070202, ok);
    latency("latency_first");
    drain();

    send(32'h04030201, 1'b1, 32'h01020304, 32'h01020304, ok);
    send(32'h01020304, 1'b0, 32'h04030201, 32'h04030201, ok);
    drain();

    send(32'h7F80FF01, 1'b0, 32'hFF807F01, 32'h7F01FF80, ok);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_in[i], bp_desc[i], bp_exp[i], bp_exp[i], ok);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bu.sort_rdy = 1'b0;
        repeat (6) @(posedge clk);
        #1 bu.sort_rdy = 1'b1;
      end
    join
    drain();

    send(32'h04030201, 1'b1, 32'h01020304, 32'h01020304, ok);
    send(32'h00203010, 1'b0, 32'h30201000, 32'h30201000, ok);
    send(32'h06010505, 1'b1, 32'h01050506, 32'h01050506, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_u.delete();
    q_s.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", bu.sort_val, 0);
    end
    @(posedge clk); #1;
    send(32'h1140007F, 1'b0, 32'h7F401100, 32'h7F401100, ok);
    latency("latency_after_rst");
    drain();

    fork
      begin
        for (int i = 0; i < 200; i++) begin
          d   = $urandom;
          dsc = 1'($urandom_range(0, 1));
          send(d, dsc, model(d, dsc, 0), model(d, dsc, 1), ok);
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bu.sort_rdy = ($urandom_range(0, 3) != 0);
        end
        bu.sort_rdy = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
